// File: rtl/reservoir_accumulator_pkg.sv
// Shared definitions for the reservoir accumulator and its activation stage.
//   clog2 / prod_width / acc_width : derived datapath widths
//   state_e                        : accumulator control states
//   clip_hi / clip_lo              : symmetric activation clip bounds
package reservoir_accumulator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_ACT,
    ST_DONE
  } state_e;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of one weighted product.
  function automatic int prod_width(input int data_width, input int weight_size);
    return data_width + weight_size - 1;
  endfunction

  // Accumulator width: wide enough that R products can never overflow.
  function automatic int acc_width(input int data_width, input int weight_size,
                                   input int reservoir_size);
    return prod_width(data_width, weight_size) + clog2(reservoir_size);
  endfunction

  // Symmetric range: the most negative code is never produced.
  function automatic longint clip_hi(input int data_width);
    return (longint'(1) << (data_width - 1)) - 1;
  endfunction

  function automatic longint clip_lo(input int data_width);
    return -clip_hi(data_width);
  endfunction

endpackage

// File: rtl/reservoir_accumulator_hard_tanh_clip.sv
// hard_tanh_clip: combinational shift-and-clip activation.
//   value_i : acc_width-bit signed sum
//   data_o  : data_width-bit signed activated value
//   sat_o   : clip was active
module hard_tanh_clip
  import reservoir_accumulator_pkg::*;
#(
  parameter int data_width = 3,
  parameter int acc_width  = 36,
  parameter int frac_shift = 30
) (
  input  logic signed [acc_width-1:0]  value_i,
  output logic signed [data_width-1:0] data_o,
  output logic                         sat_o
);

  localparam logic signed [acc_width-1:0] HI = acc_width'(clip_hi(data_width));
  localparam logic signed [acc_width-1:0] LO = acc_width'(clip_lo(data_width));

  logic signed [acc_width-1:0] shifted;

  always_comb begin
    // Arithmetic shift floors toward minus infinity.
    shifted = value_i >>> frac_shift;
    data_o  = shifted[data_width-1:0];
    sat_o   = 1'b0;
    if (shifted > HI) begin
      data_o = HI[data_width-1:0];
      sat_o  = 1'b1;
    end else if (shifted < LO) begin
      data_o = LO[data_width-1:0];
      sat_o  = 1'b1;
    end
  end

endmodule

// File: rtl/reservoir_accumulator.sv
// reservoir_accumulator: serially sums R signed products of one neuron and
// applies the shift-and-clip activation. One vector in flight at a time.
//   iClk, iRst     : clock, asynchronous active-high reset
//   iValue, iValid : packed products in (element i at [(i+1)*P-1 : i*P])
//   oReady         : high only while idle
//   oData, oSat    : activated neuron state and clip flag
//   oValid, iReady : output handshake
module reservoir_accumulator
  import reservoir_accumulator_pkg::*;
#(
  parameter int data_width     = 3,
  parameter int weight_size    = 32,
  parameter int reservoir_size = 3,
  parameter int frac_shift     = 30
) (
  input  logic                                                         iClk,
  input  logic                                                         iRst,
  input  logic [prod_width(data_width, weight_size)*reservoir_size-1:0] iValue,
  input  logic                                                         iValid,
  output logic                                                         oReady,
  output logic [data_width-1:0]                                        oData,
  output logic                                                         oValid,
  input  logic                                                         iReady,
  output logic                                                         oSat
);

  localparam int P  = prod_width(data_width, weight_size);
  localparam int R  = reservoir_size;
  localparam int A  = acc_width(data_width, weight_size, reservoir_size);
  localparam int IW = (clog2(R) > 0) ? clog2(R) : 1;
  localparam logic [IW-1:0] LAST = IW'(R - 1);

  state_e                state_q, state_d;
  logic [P*R-1:0]        vec_q, vec_d;
  logic signed [A-1:0]   acc_q, acc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [data_width-1:0] data_q, data_d;
  logic                  sat_q, sat_d;

  logic signed [P-1:0]          prod;
  logic signed [A-1:0]          prod_ext;
  logic signed [data_width-1:0] clip_data;
  logic                         clip_sat;

  hard_tanh_clip #(
    .data_width(data_width),
    .acc_width (A),
    .frac_shift(frac_shift)
  ) u_clip (
    .value_i(acc_q),
    .data_o (clip_data),
    .sat_o  (clip_sat)
  );

  always_comb begin
    prod     = vec_q[int'(idx_q)*P +: P];
    prod_ext = A'(prod);
  end

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    data_d  = data_q;
    sat_d   = sat_q;
    case (state_q)
      ST_IDLE: begin
        if (iValid) begin
          vec_d   = iValue;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        acc_d = acc_q + prod_ext;
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) begin
          idx_d   = '0;
          state_d = ST_ACT;
        end
      end
      ST_ACT: begin
        data_d  = clip_data;
        sat_d   = clip_sat;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (iReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= ST_IDLE;
      vec_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
    end
  end

  assign oReady = (state_q == ST_IDLE);
  assign oValid = (state_q == ST_DONE);
  assign oData  = data_q;
  assign oSat   = sat_q;

endmodule

// File: tb/tb_reservoir_accumulator.sv
module tb_reservoir_accumulator;

  localparam int D  = 3;
  localparam int P  = 34;
  localparam int R  = 3;
  localparam int LAT = R + 1;

  logic           iClk = 1'b0;
  logic           iRst = 1'b1;
  logic [P*R-1:0] iValue = '0;
  logic           iValid = 1'b0;
  logic           oReady;
  logic [D-1:0]   oData;
  logic           oValid;
  logic           iReady = 1'b0;
  logic           oSat;

  int checks = 0;
  int errors = 0;

  reservoir_accumulator #(
    .data_width    (3),
    .weight_size   (32),
    .reservoir_size(3),
    .frac_shift    (30)
  ) dut (
    .iClk  (iClk),
    .iRst  (iRst),
    .iValue(iValue),
    .iValid(iValid),
    .oReady(oReady),
    .oData (oData),
    .oValid(oValid),
    .iReady(iReady),
    .oSat  (oSat)
  );

  always #5 iClk = ~iClk;

  // Reference: plain integer sum, floor shift, symmetric clip to +-3.
  function automatic void ref_model(input longint a, input longint b, input longint c,
                                    output logic [D-1:0] d, output logic s);
    longint sum;
    longint sh;
    sum = a + b + c;
    sh  = sum >>> 30;
    s   = 1'b0;
    if (sh > 3) begin
      sh = 3;
      s  = 1'b1;
    end else if (sh < -3) begin
      sh = -3;
      s  = 1'b1;
    end
    d = 3'(sh);
  endfunction

  function automatic logic [P*R-1:0] pack(input longint a, input longint b, input longint c);
    logic [63:0] ua, ub, uc;
    ua = a; ub = b; uc = c;
    return {uc[P-1:0], ub[P-1:0], ua[P-1:0]};
  endfunction

  function automatic longint rand_prod();
    longint r;
    r = longint'({$urandom, $urandom});
    return r >>> (30 + $urandom_range(0, 6));
  endfunction

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  // Present a vector and hold it until the accept edge; returns after it.
  task automatic drive_accept(input logic [P*R-1:0] vec, input string name);
    int n;
    n = 0;
    while (!oReady && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (!oReady) begin
      errors++;
      $display("FAIL %s ready_timeout oReady=%0b required=1", name, oReady);
    end
    iValue = vec;
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    iValue = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Counts edges after the accept edge until oValid; noise on iValid/iReady.
  task automatic wait_valid(output int lat, input string name);
    lat = 0;
    while (!oValid && lat < 30) begin
      iValid = 1'($urandom);
      iReady = 1'($urandom);
      iValue = {$urandom, $urandom, $urandom, $urandom};
      tick();
      lat++;
    end
    iValid = 1'b0;
    iReady = 1'b0;
    checks++;
    if (!oValid) begin
      errors++;
      $display("FAIL %s valid_timeout oValid=%0b required=1", name, oValid);
    end
  endtask

  // Full transaction with optional backpressure cycles in DONE.
  task automatic run_vector(input longint a, input longint b, input longint c,
                            input int hold, input string name);
    logic [D-1:0] exp_d;
    logic         exp_s;
    int           lat;
    ref_model(a, b, c, exp_d, exp_s);
    drive_accept(pack(a, b, c), name);
    checks++;
    if (oReady !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_ready oReady=%0b required=0", name, oReady);
    end
    wait_valid(lat, name);
    checks++;
    if (lat != LAT) begin
      errors++;
      $display("FAIL %s latency got=%0d required=%0d", name, lat, LAT);
    end
    checks++;
    if (oData !== exp_d || oSat !== exp_s) begin
      errors++;
      $display("FAIL %s result data=%b sat=%b required data=%b sat=%b",
               name, oData, oSat, exp_d, exp_s);
    end
    for (int i = 0; i < hold; i++) begin
      iValid = 1'b1;
      iValue = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checks++;
      if (oValid !== 1'b1 || oReady !== 1'b0 || oData !== exp_d || oSat !== exp_s) begin
        errors++;
        $display("FAIL %s hold%0d valid=%b ready=%b data=%b sat=%b required 1 0 %b %b",
                 name, i, oValid, oReady, oData, oSat, exp_d, exp_s);
      end
    end
    iValid = 1'b0;
    iReady = 1'b1;
    tick();
    iReady = 1'b0;
    checks++;
    if (oValid !== 1'b0 || oReady !== 1'b1) begin
      errors++;
      $display("FAIL %s release valid=%b ready=%b required valid=0 ready=1",
               name, oValid, oReady);
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (oValid !== 1'b0 || oReady !== 1'b1 || oData !== 3'b000 || oSat !== 1'b0) begin
      errors++;
      $display("FAIL %s valid=%b ready=%b data=%b sat=%b required 0 1 000 0",
               name, oValid, oReady, oData, oSat);
    end
  endtask

  task automatic test_reset();
    int lat;
    #2;
    check_reset_values("reset_initial");
    tick();
    #2 iRst = 1'b0;
    tick();
    // Park a saturating result in DONE, then reset between edges.
    drive_accept(pack(64'sd4294967296, 64'sd4294967296, 64'sd4294967296), "reset_pre");
    wait_valid(lat, "reset_pre");
    #3 iRst = 1'b1;
    #1 check_reset_values("reset_async_done");
    tick();
    #2 iRst = 1'b0;
    tick();
  endtask

  task automatic test_nominal();
    run_vector(64'sd1073741824, 64'sd1073741824, 0, 0, "nominal");
  endtask

  task automatic test_saturation();
    run_vector(64'sd4294967296, 64'sd4294967296, 64'sd4294967296, 0, "pos_sat");
    run_vector(-64'sd2147483648, -64'sd2147483648, -64'sd2147483648, 0, "neg_sat");
    run_vector(-64'sd1, 0, 0, 0, "floor_neg");
    run_vector(64'sd3221225472, 64'sd1, -64'sd1, 0, "edge_plus3");
  endtask

  task automatic test_backpressure();
    run_vector(-64'sd1073741824, -64'sd1073741824, 64'sd5, 5, "backpressure");
    run_vector(64'sd1073741824, 64'sd536870912, 64'sd536870912, 0, "after_bp");
  endtask

  task automatic test_reset_mid_acc();
    drive_accept(pack(64'sd4294967296, 64'sd4294967296, 64'sd4294967296), "mid_acc");
    tick();
    tick();
    #3 iRst = 1'b1;
    #1 check_reset_values("reset_mid_acc");
    tick();
    #2 iRst = 1'b0;
    tick();
    run_vector(64'sd1073741824, 0, 0, 0, "post_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      run_vector(rand_prod(), rand_prod(), rand_prod(), $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_backpressure();
    test_reset_mid_acc();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
